mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the instruction-fetch path and the load/store unit.
//  Arbitrates each cycle, with the data port having priority and an anti-starvation override for fetch.
//  Sequences the memory's fixed read latency, returns read data to the owning requester and tells the
//  control unit when the memory is busy, so the core can stall.
// PARAMETERS
//  RD_LAT      1   cycles from the mem_cs cycle to mem_rdata valid for a read; legal range 1..7
//  STARVE_LIM  4   consecutive fetch wait cycles after which fetch outranks load/store; legal range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  if_req     in   1   fetch read request; held with if_addr stable until if_gnt
//  if_addr    in   32  fetch byte address
//  if_gnt     out  1   fetch request accepted this cycle
//  if_rvalid  out  1   one-cycle pulse; if_rdata valid
//  if_rdata   out  32  fetch read data; 0 when if_rvalid=0
//  ls_req     in   1   load/store request; held with its attributes stable until ls_gnt
//  ls_we      in   1   1=store, 0=load
//  ls_mask    in   4   byte enables (bit i -> byte i)
//  ls_addr    in   32  data byte address
//  ls_wdata   in   32  store data
//  ls_gnt     out  1   load/store request accepted this cycle
//  ls_rvalid  out  1   one-cycle pulse; ls_rdata valid (loads only)
//  ls_rdata   out  32  load data; 0 when ls_rvalid=0
//  mem_cs     out  1   memory chip select
//  mem_we     out  1   memory write enable
//  mem_mask   out  4   memory byte enables
//  mem_addr   out  32  memory address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data; valid RD_LAT cycles after a read's mem_cs cycle
//  arb_busy   out  1   1 while a read is outstanding (state WAIT)
// BEHAVIOUR
//  - Reset: state=IDLE, owner=NONE, lat_cnt=0, starve_cnt=0.
//    All outputs are 0 during and after reset until a request arrives.
//  - States:
//    IDLE: may grant; a granted read goes to WAIT; a granted write stays in IDLE.
//    WAIT: no grants; lat_cnt counts up from 1. When lat_cnt==RD_LAT, assert the owner's rvalid
//          and pass mem_rdata through to its rdata; next state is IDLE, owner=NONE.
//  - Grants:
//    - Made only in IDLE, at most one per cycle. gnt and the mem_* outputs are combinational
//      from the requests in that same cycle; mem_cs=1 only in a grant cycle.
//    - Priority: ls wins if both request, unless starve_cnt==STARVE_LIM, in which case if wins.
//  - Fetch port: mem_we=0 and mem_mask=4'hF for every fetch.
//  - Store: single-cycle occupancy; no rvalid. Back-to-back stores are granted every cycle.
//  - Read: occupies the memory for RD_LAT+1 cycles (grant cycle + RD_LAT WAIT cycles).
//    The earliest next grant is the cycle after rvalid.
//  - starve_cnt:
//    - increments (saturating at STARVE_LIM) in each cycle with if_req=1 and if_gnt=0;
//    - clears on if_gnt or when if_req=0.
//  - When idle (no grant), mem_* outputs are 0 and rdata outputs are 0.
//  - Requesters must not drop req before gnt; dropping it early is a protocol violation (asserted in TB).
//  - Asynchronous reset mid-WAIT: the outstanding read is abandoned and no rvalid is issued.
//    After reset the first request is granted normally.
// TESTING
//  1. Reset with both reqs held -> all outputs 0; after release, ls wins: ls_gnt=1, if_gnt=0, mem_we=ls_we.
//  2. RD_LAT=2, if read of 0x100 in cycle 0 -> mem_cs=1 only in c0, arb_busy=1 in c1-c2,
//     if_rvalid=1 with mem_rdata in c2, next grant no earlier than c3.
//  3. Three back-to-back stores (mask 4'b0011, 4'b1100, 4'hF) -> ls_gnt=1 in 3 consecutive cycles,
//     mem_mask matches each store, no ls_rvalid.
//  4. STARVE_LIM=4, ls stores every cycle with if_req held -> if_gnt=1 in the 5th cycle;
//     starve_cnt clears; ls wins again the next cycle.
//  5. Reset asserted in WAIT of an ls load -> no ls_rvalid; arb_busy=0 at once;
//     a post-reset fetch is granted on its first cycle.
//  6. if and ls loads issued alternately -> each rvalid goes only to the granted owner;
//     the other port's rdata stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of fetch, load/store and memory-side signals shared by
//               the memory port arbiter and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // load/store port
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_mask;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  // memory side
  logic        mem_cs;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // stall indication to control
  logic        arb_busy;

  // arbiter view
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_mask, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_cs, mem_we, mem_mask, mem_addr, mem_wdata, arb_busy
  );

  // requester/memory view
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_mask, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_cs, mem_we, mem_mask, mem_addr, mem_wdata, arb_busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               load/store. Load/store has priority; fetch overrides it once
//               it has waited STARVE_LIM cycles. Reads hold the memory for
//               RD_LAT wait cycles and return data to the owning port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int RD_LAT     = 1,  // 1..7
  parameter int STARVE_LIM = 4   // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} owner_t;

  localparam logic [2:0] c_rd_lat     = 3'(RD_LAT);
  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);

  state_t     r_state;
  owner_t     r_owner;
  logic [2:0] r_lat_cnt;
  logic [3:0] r_starve_cnt;

  logic w_can_grant;
  logic w_if_wins;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_rd_done;

  // Grant decision: only in IDLE and never while reset is asserted
  always_comb begin
    w_can_grant = (r_state == S_IDLE) && !reset;
    w_if_wins   = bus.if_req && (!bus.ls_req || (r_starve_cnt == c_starve_lim));
    w_if_gnt    = w_can_grant && w_if_wins;
    w_ls_gnt    = w_can_grant && bus.ls_req && !w_if_wins;
    w_rd_done   = (r_state == S_WAIT) && (r_lat_cnt == c_rd_lat);
  end

  // Memory request, grants and read-data steering; everything is 0 when idle
  always_comb begin
    bus.if_gnt    = w_if_gnt;
    bus.ls_gnt    = w_ls_gnt;
    bus.mem_cs    = w_if_gnt || w_ls_gnt;
    bus.mem_we    = w_ls_gnt && bus.ls_we;
    bus.mem_mask  = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (w_if_gnt) begin
      bus.mem_mask = 4'hF;
      bus.mem_addr = bus.if_addr;
    end else if (w_ls_gnt) begin
      bus.mem_mask  = bus.ls_mask;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_wdata;
    end
    bus.if_rvalid = w_rd_done && (r_owner == OWN_IF);
    bus.ls_rvalid = w_rd_done && (r_owner == OWN_LS);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
    bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : 32'h0;
    bus.arb_busy  = (r_state == S_WAIT);
  end

  // Read sequencer: a granted read waits RD_LAT cycles, then returns to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_NONE;
      r_lat_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_if_gnt || (w_ls_gnt && !bus.ls_we)) begin
            r_state   <= S_WAIT;
            r_owner   <= w_if_gnt ? OWN_IF : OWN_LS;
            r_lat_cnt <= 3'd1;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == c_rd_lat) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_NONE;
            r_lat_cnt <= 3'd0;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_owner   <= OWN_NONE;
          r_lat_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Fetch starvation counter: counts ungranted fetch cycles, saturating at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (bus.if_req && !w_if_gnt) begin
      if (r_starve_cnt != c_starve_lim) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Requesters are
//               queues; a transaction-level model predicts grants, memory
//               traffic and read returns from the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_LIM = 4;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ls_txn_t;

  logic [31:0] ifq[$];
  ls_txn_t     lsq[$];
  logic [31:0] mem_model [logic [29:0]];

  // transaction-level model state
  int          m_wait_left;  // memory-occupied cycles still to come
  int          m_owner;      // 1 = fetch, 2 = load/store
  int          m_starve;     // consecutive ungranted fetch cycles
  logic [31:0] m_rd_data;
  logic        p_if_waiting;
  logic [31:0] p_if_addr;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait_left  = 0;
    m_owner      = 0;
    m_starve     = 0;
    p_if_waiting = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(bus.if_gnt),    32'h0);
    chk({tag, "_ls_gnt"},    32'(bus.ls_gnt),    32'h0);
    chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'h0);
    chk({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid), 32'h0);
    chk({tag, "_if_rdata"},  bus.if_rdata,       32'h0);
    chk({tag, "_ls_rdata"},  bus.ls_rdata,       32'h0);
    chk({tag, "_mem_cs"},    32'(bus.mem_cs),    32'h0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
    chk({tag, "_mem_mask"},  32'(bus.mem_mask),  32'h0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'h0);
    chk({tag, "_arb_busy"},  32'(bus.arb_busy),  32'h0);
  endtask

  // One clock cycle: entered at posedge+1, drives, checks at negedge, updates model
  task automatic run_cycle();
    logic        e_if_gnt, e_ls_gnt, e_cs, e_we, e_if_rv, e_ls_rv;
    logic [3:0]  e_mask;
    logic [31:0] e_addr, e_wdata, e_if_rd, e_ls_rd, s;
    ls_txn_t     t;
    bus.if_req  = (ifq.size() > 0);
    bus.if_addr = bus.if_req ? ifq[0] : $urandom();
    bus.ls_req  = (lsq.size() > 0);
    if (bus.ls_req) begin
      t = lsq[0];
    end else begin
      t.we = 1'($urandom()); t.mask = 4'($urandom()); t.addr = $urandom(); t.wdata = $urandom();
    end
    bus.ls_we = t.we; bus.ls_mask = t.mask; bus.ls_addr = t.addr; bus.ls_wdata = t.wdata;
    if (p_if_waiting) begin
      chk("proto_if_req_held", 32'(bus.if_req), 32'h1);
      chk("proto_if_addr_held", bus.if_addr, p_if_addr);
    end
    e_if_gnt = 0; e_ls_gnt = 0; e_cs = 0; e_we = 0; e_mask = 0; e_addr = 0; e_wdata = 0;
    e_if_rv = 0; e_ls_rv = 0; e_if_rd = 0; e_ls_rd = 0;
    if (m_wait_left == 0) begin
      if (bus.if_req && (!bus.ls_req || m_starve >= STARVE_LIM)) e_if_gnt = 1;
      else if (bus.ls_req) e_ls_gnt = 1;
    end
    if (e_if_gnt) begin
      e_cs = 1; e_mask = 4'hF; e_addr = bus.if_addr;
    end
    if (e_ls_gnt) begin
      e_cs = 1; e_we = t.we; e_mask = t.mask; e_addr = t.addr; e_wdata = t.wdata;
    end
    if (m_wait_left == 1) begin
      bus.mem_rdata = m_rd_data;
      if (m_owner == 1) begin e_if_rv = 1; e_if_rd = m_rd_data; end
      else begin e_ls_rv = 1; e_ls_rd = m_rd_data; end
    end else begin
      bus.mem_rdata = $urandom();
    end
    #4;
    chk("if_gnt",    32'(bus.if_gnt),    32'(e_if_gnt));
    chk("ls_gnt",    32'(bus.ls_gnt),    32'(e_ls_gnt));
    chk("mem_cs",    32'(bus.mem_cs),    32'(e_cs));
    chk("mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mem_mask",  32'(bus.mem_mask),  32'(e_mask));
    chk("mem_addr",  bus.mem_addr,       e_addr);
    chk("mem_wdata", bus.mem_wdata,      e_wdata);
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
    chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(e_ls_rv));
    chk("if_rdata",  bus.if_rdata,       e_if_rd);
    chk("ls_rdata",  bus.ls_rdata,       e_ls_rd);
    chk("arb_busy",  32'(bus.arb_busy),  32'(m_wait_left > 0));
    @(posedge clk); #1;
    if (m_wait_left > 0) m_wait_left--;
    if (e_if_gnt) begin
      m_rd_data = word_of(bus.if_addr); m_owner = 1; m_wait_left = RD_LAT;
      void'(ifq.pop_front());
    end
    if (e_ls_gnt) begin
      void'(lsq.pop_front());
      if (t.we) begin
        s = word_of(t.addr);
        for (int b = 0; b < 4; b++) if (t.mask[b]) s[8*b +: 8] = t.wdata[8*b +: 8];
        mem_model[t.addr[31:2]] = s;
      end else begin
        m_rd_data = word_of(t.addr); m_owner = 2; m_wait_left = RD_LAT;
      end
    end
    if (bus.if_req && !e_if_gnt) m_starve = (m_starve + 1 > STARVE_LIM) ? STARVE_LIM : m_starve + 1;
    else m_starve = 0;
    p_if_waiting = bus.if_req && !e_if_gnt;
    p_if_addr    = bus.if_addr;
  endtask

  task automatic drain();
    int n = 0;
    while ((ifq.size() > 0 || lsq.size() > 0 || m_wait_left > 0) && n < 300) begin
      run_cycle();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(n), 32'h0);
  endtask

  function automatic ls_txn_t mk_ls(input logic we, input logic [3:0] mask,
                                    input logic [31:0] addr, input logic [31:0] wdata);
    ls_txn_t t;
    t.we = we; t.mask = mask; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests held: all outputs stay 0
    model_reset();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_mask = 4'hF;
    bus.ls_addr = 32'h80; bus.ls_wdata = 32'hCAFE_F00D;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk_all_zero("rst_a");
    @(posedge clk); #4;
    chk_all_zero("rst_b");
    ifq.push_back(32'h40);
    lsq.push_back(mk_ls(1'b1, 4'hF, 32'h80, 32'hCAFE_F00D));
    @(posedge clk); #1;
    reset = 1'b0;
    drain();

    // Fetch read of 0x100, then a load arriving during its wait
    ifq.push_back(32'h100);
    run_cycle();
    lsq.push_back(mk_ls(1'b0, 4'hF, 32'h100, 32'h0));
    drain();

    // Three back-to-back stores followed by a read-back
    lsq.push_back(mk_ls(1'b1, 4'b0011, 32'h200, 32'h1111_2222));
    lsq.push_back(mk_ls(1'b1, 4'b1100, 32'h200, 32'h3333_4444));
    lsq.push_back(mk_ls(1'b1, 4'hF,    32'h204, 32'h5555_6666));
    lsq.push_back(mk_ls(1'b0, 4'hF,    32'h200, 32'h0));
    drain();

    // Fetch starved by a stream of stores
    for (int i = 0; i < 8; i++) lsq.push_back(mk_ls(1'b1, 4'hF, 32'h300 + 32'(4*i), 32'(i)));
    ifq.push_back(32'h300);
    drain();

    // Reset during the wait of a load: read abandoned
    lsq.push_back(mk_ls(1'b0, 4'hF, 32'h400, 32'h0));
    run_cycle();
    run_cycle();
    bus.mem_rdata = word_of(32'h400);
    reset = 1'b1;
    #1;
    chk("rst_wait_arb_busy",  32'(bus.arb_busy),  32'h0);
    chk("rst_wait_ls_rvalid", 32'(bus.ls_rvalid), 32'h0);
    chk("rst_wait_ls_rdata",  bus.ls_rdata,       32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    ifq.push_back(32'h500);
    drain();

    // Alternating fetch and load reads
    for (int i = 0; i < 4; i++) begin
      ifq.push_back(32'h600 + 32'(8*i));
      lsq.push_back(mk_ls(1'b0, 4'hF, 32'h200 + 32'(4*(i%2)), 32'h0));
    end
    drain();

    // Randomised traffic on a small address window
    for (int c = 0; c < 400; c++) begin
      if (ifq.size() < 2 && $urandom_range(0, 2) == 0)
        ifq.push_back({24'h0, 6'($urandom()), 2'b00});
      if (lsq.size() < 3 && $urandom_range(0, 1) == 0)
        lsq.push_back(mk_ls(1'($urandom()), 4'($urandom()), {24'h0, 6'($urandom()), 2'b00}, $urandom()));
      run_cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
